fpu_scoreboard: RTL

- Consumer of the FP decode control outputs: use_rs1/use_rs2, reg_write and the is_hazard_0/1/2 latency classes.
- Tracks per-FP-register write-pending countdowns for in-flight FP operations.
- Raises a combinational issue stall on RAW/WAW hazards against the instruction in decode.
- Sits between FP decode and the FP execute issue point. FP units are never stalled; countdowns always advance.

---
 rtl/fpu_pkg.sv | 21 ++
 rtl/fpu_sb_entry.sv | 27 ++
 rtl/fpu_scoreboard.sv | 66 ++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP register-file and latency-class constants
package fpu_pkg;

   localparam int AW   = 5;
   localparam int NREG = 1 << AW;
   localparam int CW   = 2;

   localparam logic [CW-1:0] LAT_NONE = 2'd0;
   localparam logic [CW-1:0] LAT_H0   = 2'd1;
   localparam logic [CW-1:0] LAT_H1   = 2'd2;
   localparam logic [CW-1:0] LAT_H2   = 2'd3;

   // Hazard classes are nested, so the highest asserted class wins.
   function automatic logic [CW-1:0] lat_decode(input logic h0, input logic h1, input logic h2);
      if (h2)      return LAT_H2;
      else if (h1) return LAT_H1;
      else if (h0) return LAT_H0;
      else         return LAT_NONE;
   endfunction

endpackage

// File: rtl/fpu_sb_entry.sv
// rtl/fpu_sb_entry.sv - write-pending countdown for one FP register
module fpu_sb_entry
   import fpu_pkg::*;
(
   input  logic          clk,
   input  logic          rstn,
   input  logic          set,
   input  logic [CW-1:0] set_val,
   input  logic          clear,
   output logic [CW-1:0] cnt,
   output logic          busy
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (set)
         cnt <= set_val;
      else if (cnt != '0)
         cnt <= cnt - CW'(1);
   end

   assign busy = (cnt != '0);

endmodule

// File: rtl/fpu_scoreboard.sv
// rtl/fpu_scoreboard.sv - FP register scoreboard raising RAW/WAW issue stalls
module fpu_scoreboard
   import fpu_pkg::*;
(
   input  logic            clk,
   input  logic            rstn,
   input  logic            issue_valid,
   input  logic            hold_in,
   input  logic            flush,
   input  logic [AW-1:0]   rd,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   input  logic            use_rs1,
   input  logic            use_rs2,
   input  logic            reg_write,
   input  logic            is_hazard_0,
   input  logic            is_hazard_1,
   input  logic            is_hazard_2,
   output logic            stall,
   output logic            issue_fire,
   output logic [NREG-1:0] busy_vec,
   output logic [AW:0]     pending_cnt
);

   logic [CW-1:0]   lat;
   logic [CW-1:0]   cnt [NREG];
   logic [NREG-1:0] set_vec;
   logic            raw1;
   logic            raw2;
   logic            waw;

   assign lat = lat_decode(is_hazard_0, is_hazard_1, is_hazard_2);

   assign raw1 = use_rs1   & (cnt[rs1] != '0);
   assign raw2 = use_rs2   & (cnt[rs2] != '0);
   assign waw  = reg_write & (cnt[rd]  != '0);

   assign stall      = issue_valid & ~flush & (raw1 | raw2 | waw);
   assign issue_fire = issue_valid & ~hold_in & ~flush & ~stall;

   // Zero-latency writers are forwarded, so they never occupy an entry.
   always_comb begin
      set_vec = '0;
      if (issue_fire && reg_write && (lat != LAT_NONE))
         set_vec[rd] = 1'b1;
   end

   for (genvar g = 0; g < NREG; g++) begin : g_entry
      fpu_sb_entry u_entry (
         .clk     (clk),
         .rstn    (rstn),
         .set     (set_vec[g]),
         .set_val (lat),
         .clear   (flush),
         .cnt     (cnt[g]),
         .busy    (busy_vec[g])
      );
   end

   always_comb begin
      pending_cnt = '0;
      for (int i = 0; i < NREG; i++)
         pending_cnt = pending_cnt + {{AW{1'b0}}, busy_vec[i]};
   end

endmodule
